// File: rtl/mem_block_mover_if.sv
// ============================================================================
// Module      : mem_block_mover_if
// Description : Data-memory bus between the block mover (master) and the
//               256-byte data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_block_mover_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_address,
        output mem_write_enable,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_address,
        input  mem_write_enable,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_block_mover.sv
// ============================================================================
// Module      : mem_block_mover
// Description : Block copy / block fill bus initiator for the data memory.
//               Optional running checksum of written bytes, enabled by the
//               macro MEM_BLOCK_MOVER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic              mode,
    input  wire logic [ADDR_W-1:0] src_addr,
    input  wire logic [ADDR_W-1:0] dst_addr,
    input  wire logic [ADDR_W-1:0] length,
    input  wire logic [DATA_W-1:0] fill_value,
    output logic                   busy,
    output logic                   done,
    mem_block_mover_if.master      mem
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]      checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_fill;
    logic              r_mode;
    logic [DATA_W-1:0] w_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus outputs decode only from registered state so they settle well
    // before the memory's negedge sample; reset drops write_enable at once.
    always_comb begin
        w_next               = r_state;
        busy                 = 1'b0;
        done                 = 1'b0;
        mem.mem_address      = '0;
        mem.mem_write_enable = 1'b0;
        mem.mem_wdata        = '0;
        w_wdata              = r_mode ? r_fill : r_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_next = S_DONE;
                    end else if (mode) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                busy            = 1'b1;
                mem.mem_address = r_src_ptr;
                w_next          = S_WRITE;
            end
            S_WRITE: begin
                busy                 = 1'b1;
                mem.mem_address      = r_dst_ptr;
                mem.mem_write_enable = 1'b1;
                mem.mem_wdata        = w_wdata;
                if (r_remaining == c_one) begin
                    w_next = S_DONE;
                end else if (r_mode) begin
                    w_next = S_WRITE;
                end else begin
                    w_next = S_READ;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_fill      <= '0;
            r_mode      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr   <= src_addr;
                        r_dst_ptr   <= dst_addr;
                        r_remaining <= length;
                        r_fill      <= fill_value;
                        r_mode      <= mode;
                    end
                end
                S_READ: begin
                    r_data <= mem.mem_rdata;
                end
                S_WRITE: begin
                    // Pointers wrap naturally at the address width.
                    r_dst_ptr   <= r_dst_ptr + c_one;
                    r_remaining <= r_remaining - c_one;
                    if (!r_mode) begin
                        r_src_ptr <= r_src_ptr + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (r_state == S_IDLE && start) begin
            checksum <= '0;
        end else if (r_state == S_WRITE) begin
            checksum <= checksum + w_wdata;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_block_mover.sv
// ============================================================================
// Module      : tb_mem_block_mover
// Description : Directed self-checking bench for mem_block_mover with a
//               negedge-sampling memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_block_mover;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] fill_value;
    wire        busy;
    wire        done;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    wire  [7:0] checksum;
`endif

    int n_checks;
    int n_fail;

    logic [7:0] mem_arr [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    mem_block_mover_if #(.ADDR_W(8), .DATA_W(8)) mem_bus ();

    mem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .mem        (mem_bus.master)
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory sampling on the falling edge.
    always @(negedge clk) begin
        if (pl_we) begin
            mem_arr[pl_addr] <= pl_data;
        end else if (mem_bus.mem_write_enable) begin
            mem_arr[mem_bus.mem_address] <= mem_bus.mem_wdata;
        end
        mem_bus.mem_rdata <= mem_arr[mem_bus.mem_address];
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    // Issues one command and observes a fixed window of cycles; cycle c is
    // the c-th falling edge after the posedge that sampled start.
    task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f, input int inject_at,
                           output int done_cyc, output int n_done, output int n_busy,
                           output int n_we);
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        length     = l;
        fill_value = f;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = -1;
        n_done   = 0;
        n_busy   = 0;
        n_we     = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == inject_at) begin
                start      = 1'b1;
                mode       = 1'b1;
                dst_addr   = 8'h90;
                length     = 8'd4;
                fill_value = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy) n_busy++;
            if (mem_bus.mem_write_enable) n_we++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", done);
        end
        n_checks++;
        if (mem_bus.mem_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %b want 0", mem_bus.mem_write_enable);
        end
        n_checks++;
        if (mem_bus.mem_address !== 8'h00) begin
            n_fail++; $display("FAIL reset_addr: got %h want 00", mem_bus.mem_address);
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_copy;
        logic [7:0] exp_d [4];
        logic [7:0] a;
        int dc, nd, nb, nw;
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) preload(8'h10 + 8'(i), exp_d[i]);
        run_cmd(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0, dc, nd, nb, nw);
        for (int i = 0; i < 4; i++) begin
            a = 8'h80 + 8'(i);
            n_checks++;
            if (mem_arr[a] !== exp_d[i]) begin
                n_fail++; $display("FAIL copy_data[%h]: got %h want %h", a, mem_arr[a], exp_d[i]);
            end
        end
        n_checks++;
        if (dc !== 9) begin
            n_fail++; $display("FAIL copy_latency: got %0d want 9", dc);
        end
        n_checks++;
        if (nb !== 8) begin
            n_fail++; $display("FAIL copy_busy_cycles: got %0d want 8", nb);
        end
        n_checks++;
        if (nd !== 1) begin
            n_fail++; $display("FAIL copy_done_count: got %0d want 1", nd);
        end
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        n_checks++;
        if (checksum !== 8'hEA) begin
            n_fail++; $display("FAIL copy_checksum: got %h want EA", checksum);
        end
`endif
    endtask

    task automatic test_fill_wrap;
        logic [7:0] a;
        int dc, nd, nb, nw;
        preload(8'h02, 8'h77);
        run_cmd(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 0, dc, nd, nb, nw);
        for (int i = 0; i < 4; i++) begin
            a = 8'hFE + 8'(i);
            n_checks++;
            if (mem_arr[a] !== 8'h5A) begin
                n_fail++; $display("FAIL fill_data[%h]: got %h want 5A", a, mem_arr[a]);
            end
        end
        n_checks++;
        if (mem_arr[8'h02] !== 8'h77) begin
            n_fail++; $display("FAIL fill_past_end: got %h want 77", mem_arr[8'h02]);
        end
        n_checks++;
        if (dc !== 5) begin
            n_fail++; $display("FAIL fill_latency: got %0d want 5", dc);
        end
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        n_checks++;
        if (checksum !== 8'h68) begin
            n_fail++; $display("FAIL fill_checksum: got %h want 68", checksum);
        end
`endif
    endtask

    task automatic test_zero_length;
        int dc, nd, nb, nw;
        preload(8'h50, 8'h33);
        run_cmd(1'b1, 8'h00, 8'h50, 8'd0, 8'hEE, 0, dc, nd, nb, nw);
        n_checks++;
        if (nw !== 0) begin
            n_fail++; $display("FAIL zero_we_cycles: got %0d want 0", nw);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++; $display("FAIL zero_latency: got %0d want 1", dc);
        end
        n_checks++;
        if (mem_arr[8'h50] !== 8'h33) begin
            n_fail++; $display("FAIL zero_mem: got %h want 33", mem_arr[8'h50]);
        end
        n_checks++;
        if (nb !== 0) begin
            n_fail++; $display("FAIL zero_busy: got %0d want 0", nb);
        end
    endtask

    task automatic test_start_while_busy;
        logic [7:0] exp_d [4];
        logic [7:0] a;
        int dc, nd, nb, nw;
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) preload(8'h90 + 8'(i), 8'h00);
        run_cmd(1'b0, 8'h10, 8'hA0, 8'd4, 8'h00, 3, dc, nd, nb, nw);
        for (int i = 0; i < 4; i++) begin
            a = 8'hA0 + 8'(i);
            n_checks++;
            if (mem_arr[a] !== exp_d[i]) begin
                n_fail++; $display("FAIL busy_copy_data[%h]: got %h want %h", a, mem_arr[a], exp_d[i]);
            end
        end
        n_checks++;
        if (mem_arr[8'h90] !== 8'h00) begin
            n_fail++; $display("FAIL busy_ignored_fill: got %h want 00", mem_arr[8'h90]);
        end
        n_checks++;
        if (nd !== 1) begin
            n_fail++; $display("FAIL busy_done_count: got %0d want 1", nd);
        end
        n_checks++;
        if (nw !== 4) begin
            n_fail++; $display("FAIL busy_we_cycles: got %0d want 4", nw);
        end
    endtask

    task automatic test_overlap;
        int dc, nd, nb, nw;
        preload(8'h20, 8'h11);
        preload(8'h21, 8'h22);
        run_cmd(1'b0, 8'h20, 8'h21, 8'd2, 8'h00, 0, dc, nd, nb, nw);
        n_checks++;
        if (mem_arr[8'h21] !== 8'h11) begin
            n_fail++; $display("FAIL overlap_21: got %h want 11", mem_arr[8'h21]);
        end
        n_checks++;
        if (mem_arr[8'h22] !== 8'h11) begin
            n_fail++; $display("FAIL overlap_22: got %h want 11", mem_arr[8'h22]);
        end
    endtask

    task automatic test_reset_mid_write;
        int nd;
        preload(8'h40, 8'h00);
        preload(8'h41, 8'h00);
        @(negedge clk);
        start      = 1'b1;
        mode       = 1'b1;
        dst_addr   = 8'h40;
        length     = 8'd8;
        fill_value = 8'h3C;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_bus.mem_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL midrst_we_before: got %b want 1", mem_bus.mem_write_enable);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_bus.mem_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL midrst_we_async: got %b want 0", mem_bus.mem_write_enable);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got %b want 0", busy);
        end
        #1 reset_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 0) begin
            n_fail++; $display("FAIL midrst_done_count: got %0d want 0", nd);
        end
        n_checks++;
        if (mem_arr[8'h40] !== 8'h3C) begin
            n_fail++; $display("FAIL midrst_partial_40: got %h want 3C", mem_arr[8'h40]);
        end
        n_checks++;
        if (mem_arr[8'h41] !== 8'h00) begin
            n_fail++; $display("FAIL midrst_partial_41: got %h want 00", mem_arr[8'h41]);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = 8'h00;
        dst_addr   = 8'h00;
        length     = 8'h00;
        fill_value = 8'h00;
        pl_we      = 1'b0;
        pl_addr    = 8'h00;
        pl_data    = 8'h00;
        test_reset;
        test_copy;
        test_fill_wrap;
        test_zero_length;
        test_start_while_busy;
        test_overlap;
        test_reset_mid_write;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
